// File: rtl/vga_mem_pkg.sv
// Shared definitions for the VGA frame-buffer SDRAM command path.
// Holds the SDRAM address field widths, the fixed bank used by the
// frame buffer, and the scheduler FSM state type.
package vga_mem_pkg;

  localparam int unsigned ROW_WIDTH  = 13;
  localparam int unsigned COL_WIDTH  = 9;
  localparam int unsigned BANK_WIDTH = 2;
  localparam int unsigned LINE_WIDTH = 10;
  localparam int unsigned ADDR_WIDTH = BANK_WIDTH + ROW_WIDTH + COL_WIDTH;

  localparam logic [BANK_WIDTH-1:0] VGA_BANK = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    RD_CMD,
    WR_CMD
  } state_e;

endpackage

// File: rtl/vga_mem_scheduler_if.sv
// SDRAM controller command port.
//   mem_valid : command valid (scheduler -> controller)
//   mem_write : 1 = write, 0 = read
//   mem_addr  : {bank, row, col}
//   mem_ready : controller accepts the command when high with mem_valid
// master = scheduler side, slave = SDRAM controller side.
interface vga_mem_scheduler_if;
  import vga_mem_pkg::*;

  logic                  mem_valid;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ready;

  modport master (
    output mem_valid,
    output mem_write,
    output mem_addr,
    input  mem_ready
  );

  modport slave (
    input  mem_valid,
    input  mem_write,
    input  mem_addr,
    output mem_ready
  );

endinterface

// File: rtl/vga_addr_form.sv
// Combinational SDRAM address former.
//   row_in  : display/write row (zero-extended to ROW_WIDTH)
//   row_off : buffer row offset
//   col_in  : column
//   addr    : {VGA_BANK, (row_in + row_off) mod 2^ROW_WIDTH, col_in}
module vga_addr_form
  import vga_mem_pkg::*;
(
  input  logic [LINE_WIDTH-1:0] row_in,
  input  logic [ROW_WIDTH-1:0]  row_off,
  input  logic [COL_WIDTH-1:0]  col_in,
  output logic [ADDR_WIDTH-1:0] addr
);

  logic [ROW_WIDTH-1:0] row_sum;

  always_comb begin
    // The sum is kept at ROW_WIDTH bits so the row wraps silently.
    row_sum = {{(ROW_WIDTH - LINE_WIDTH){1'b0}}, row_in} + row_off;
    addr    = {VGA_BANK, row_sum, col_in};
  end

endmodule

// File: rtl/vga_mem_scheduler.sv
// SDRAM command scheduler for the VGA frame-buffer path.
//   clk, rst_n    : clock, asynchronous active-low reset
//   vsync_pulse   : start-of-frame strobe; performs a pending buffer swap
//   swap_req      : writer finished the back buffer
//   rd_line_req   : fetch display line rd_line (BURSTS_PER_LINE reads)
//   rd_line_done  : pulse when the last read burst of a line is accepted
//   wr_req        : write burst pending (level, held until wr_ack)
//   wr_row/wr_col : write burst location in the back buffer
//   wr_ack        : pulse when the write command is accepted
//   mem           : SDRAM controller command port (master side)
//   front_buf     : buffer currently displayed
// Reads have strict priority over writes; a command in flight is never
// preempted. Buffer offsets are latched on command start so a swap in
// the middle of a command does not disturb it.
module vga_mem_scheduler
  import vga_mem_pkg::*;
#(
  parameter int unsigned          BURST_LEN       = 64,
  parameter int unsigned          BURSTS_PER_LINE = 5,
  parameter logic [ROW_WIDTH-1:0] BUF0_OFFSET     = 13'd0,
  parameter logic [ROW_WIDTH-1:0] BUF1_OFFSET     = 13'd512
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vsync_pulse,
  input  logic                  swap_req,
  input  logic                  rd_line_req,
  input  logic [LINE_WIDTH-1:0] rd_line,
  output logic                  rd_line_done,
  input  logic                  wr_req,
  input  logic [LINE_WIDTH-1:0] wr_row,
  input  logic [COL_WIDTH-1:0]  wr_col,
  output logic                  wr_ack,
  vga_mem_scheduler_if.master   mem,
  output logic                  front_buf
);

  localparam int unsigned BCNT_W =
    (BURSTS_PER_LINE > 1) ? $clog2(BURSTS_PER_LINE) : 1;
  localparam logic [BCNT_W-1:0] LAST_BURST = BCNT_W'(BURSTS_PER_LINE - 1);

  state_e                state_q, state_d;
  logic [BCNT_W-1:0]     burst_cnt_q, burst_cnt_d;
  logic [ROW_WIDTH-1:0]  rd_off_q, rd_off_d;
  logic [ROW_WIDTH-1:0]  wr_off_q, wr_off_d;
  logic                  rd_pending_q, rd_pending_d;
  logic [LINE_WIDTH-1:0] rd_line_q, rd_line_d;
  logic                  front_buf_q, front_buf_d;
  logic                  swap_pending_q, swap_pending_d;
  logic                  mem_valid_q, mem_valid_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;

  logic [LINE_WIDTH-1:0] row_sel;
  logic [ROW_WIDTH-1:0]  off_sel;
  logic [COL_WIDTH-1:0]  col_sel;
  logic [COL_WIDTH-1:0]  rd_col;
  logic [ADDR_WIDTH-1:0] form_addr;
  logic                  xfer;
  logic                  rd_clear;
  logic                  swap_now;

  // Address source mux: the write port while writing, else the latched read line.
  always_comb begin
    rd_col = COL_WIDTH'(burst_cnt_q) * COL_WIDTH'(BURST_LEN);
    if (state_q == WR_CMD) begin
      row_sel = wr_row;
      off_sel = wr_off_q;
      col_sel = wr_col;
    end else begin
      row_sel = rd_line_q;
      off_sel = rd_off_q;
      col_sel = rd_col;
    end
  end

  vga_addr_form u_addr_form (
    .row_in  (row_sel),
    .row_off (off_sel),
    .col_in  (col_sel),
    .addr    (form_addr)
  );

  always_comb begin
    state_d      = state_q;
    burst_cnt_d  = burst_cnt_q;
    rd_off_d     = rd_off_q;
    wr_off_d     = wr_off_q;
    mem_valid_d  = mem_valid_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    rd_line_done = 1'b0;
    wr_ack       = 1'b0;
    rd_clear     = 1'b0;
    xfer         = mem_valid_q && mem.mem_ready;

    unique case (state_q)
      IDLE: begin
        // A request strobed this very cycle already counts as pending,
        // so a simultaneous write request cannot overtake it.
        if (rd_pending_q || rd_line_req) begin
          state_d     = RD_CMD;
          burst_cnt_d = '0;
          rd_off_d    = front_buf_q ? BUF1_OFFSET : BUF0_OFFSET;
        end else if (wr_req) begin
          state_d  = WR_CMD;
          wr_off_d = front_buf_q ? BUF0_OFFSET : BUF1_OFFSET;
        end
      end
      RD_CMD: begin
        if (xfer) begin
          mem_valid_d = 1'b0;
          burst_cnt_d = burst_cnt_q + BCNT_W'(1);
          if (burst_cnt_q == LAST_BURST) begin
            rd_line_done = 1'b1;
            rd_clear     = 1'b1;
            burst_cnt_d  = '0;
            state_d      = IDLE;
          end
        end else if (!mem_valid_q) begin
          mem_valid_d = 1'b1;
          mem_write_d = 1'b0;
          mem_addr_d  = form_addr;
        end
      end
      WR_CMD: begin
        if (xfer) begin
          mem_valid_d = 1'b0;
          wr_ack      = 1'b1;
          state_d     = IDLE;
        end else if (!mem_valid_q) begin
          mem_valid_d = 1'b1;
          mem_write_d = 1'b1;
          mem_addr_d  = form_addr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pending read line and buffer swap bookkeeping.
  always_comb begin
    rd_pending_d   = (rd_pending_q && !rd_clear) || rd_line_req;
    rd_line_d      = rd_line_req ? rd_line : rd_line_q;
    swap_now       = vsync_pulse && (swap_pending_q || swap_req);
    front_buf_d    = swap_now ? ~front_buf_q : front_buf_q;
    swap_pending_d = swap_now ? 1'b0 : (swap_pending_q || swap_req);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      burst_cnt_q    <= '0;
      rd_off_q       <= '0;
      wr_off_q       <= '0;
      rd_pending_q   <= 1'b0;
      rd_line_q      <= '0;
      front_buf_q    <= 1'b0;
      swap_pending_q <= 1'b0;
      mem_valid_q    <= 1'b0;
      mem_write_q    <= 1'b0;
      mem_addr_q     <= '0;
    end else begin
      state_q        <= state_d;
      burst_cnt_q    <= burst_cnt_d;
      rd_off_q       <= rd_off_d;
      wr_off_q       <= wr_off_d;
      rd_pending_q   <= rd_pending_d;
      rd_line_q      <= rd_line_d;
      front_buf_q    <= front_buf_d;
      swap_pending_q <= swap_pending_d;
      mem_valid_q    <= mem_valid_d;
      mem_write_q    <= mem_write_d;
      mem_addr_q     <= mem_addr_d;
    end
  end

  assign mem.mem_valid = mem_valid_q;
  assign mem.mem_write = mem_write_q;
  assign mem.mem_addr  = mem_addr_q;
  assign front_buf     = front_buf_q;

endmodule

// File: tb/tb_vga_mem_scheduler.sv
// Testbench for vga_mem_scheduler: two instances share all inputs, one
// with default buffer offsets and one with BUF1_OFFSET=8000 for row wrap.
module tb_vga_mem_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vsync_pulse, swap_req, rd_line_req, wr_req;
  logic [9:0] rd_line, wr_row;
  logic [8:0] wr_col;
  logic       done1, ack1, front1, done2, ack2, front2;
  logic       ready = 1'b0;
  logic       ready_level, rand_ready;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0, ack_cnt = 0, done_cyc = 0, ack_cyc = 0;
  bit model_front = 1'b0;
  logic [24:0] cap1[$];
  logic [24:0] cap2[$];

  vga_mem_scheduler_if bus1 ();
  vga_mem_scheduler_if bus2 ();
  assign bus1.mem_ready = ready;
  assign bus2.mem_ready = ready;

  vga_mem_scheduler dut1 (
    .clk(clk), .rst_n(rst_n), .vsync_pulse(vsync_pulse), .swap_req(swap_req),
    .rd_line_req(rd_line_req), .rd_line(rd_line), .rd_line_done(done1),
    .wr_req(wr_req), .wr_row(wr_row), .wr_col(wr_col), .wr_ack(ack1),
    .mem(bus1), .front_buf(front1)
  );

  vga_mem_scheduler #(.BUF1_OFFSET(13'd8000)) dut2 (
    .clk(clk), .rst_n(rst_n), .vsync_pulse(vsync_pulse), .swap_req(swap_req),
    .rd_line_req(rd_line_req), .rd_line(rd_line), .rd_line_done(done2),
    .wr_req(wr_req), .wr_row(wr_row), .wr_col(wr_col), .wr_ack(ack2),
    .mem(bus2), .front_buf(front2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_level;
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus1.mem_valid && bus1.mem_ready) cap1.push_back({bus1.mem_write, bus1.mem_addr});
    if (bus2.mem_valid && bus2.mem_ready) cap2.push_back({bus2.mem_write, bus2.mem_addr});
    if (done1) begin done_cnt = done_cnt + 1; done_cyc = cyc; end
    if (ack1) begin ack_cnt = ack_cnt + 1; ack_cyc = cyc; end
  end

  // Reference: {write, 2'b01, (row+off) mod 8192, col mod 512}
  function automatic logic [24:0] model_cmd(input bit wr, input int unsigned row,
                                            input int unsigned off, input int unsigned col);
    int unsigned a;
    a = 32'h0040_0000 + (((row + off) % 8192) << 9) + (col % 512);
    return {wr, a[23:0]};
  endfunction

  function automatic int unsigned off1(input bit buf_sel);
    return buf_sel ? 512 : 0;
  endfunction

  function automatic int unsigned off2(input bit buf_sel);
    return buf_sel ? 8000 : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rd(input logic [9:0] line);
    rd_line = line;
    rd_line_req = 1'b1;
    tick();
    rd_line_req = 1'b0;
  endtask

  task automatic wait_done(input int target, output bit ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < 600; i++) begin
      tick();
      if (done_cnt >= target) begin ok = 1'b1; break; end
    end
    tick();
    tick();
  endtask

  task automatic do_write(input logic [9:0] row, input logic [8:0] col, output bit ok);
    wr_row = row;
    wr_col = col;
    wr_req = 1'b1;
    ok = 1'b0;
    for (int unsigned i = 0; i < 600; i++) begin
      @(negedge clk);
      if (ack1) begin ok = 1'b1; break; end
    end
    @(posedge clk);
    #1;
    wr_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (bus1.mem_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus1.mem_valid); end
    checks++; if (bus1.mem_write !== 1'b0) begin errors++; $display("FAIL reset_write got %b want 0", bus1.mem_write); end
    checks++; if (bus1.mem_addr !== 24'h0) begin errors++; $display("FAIL reset_addr got %h want 000000", bus1.mem_addr); end
    checks++; if (done1 !== 1'b0 || ack1 !== 1'b0) begin errors++; $display("FAIL reset_pulses got %b%b want 00", done1, ack1); end
    checks++; if (front1 !== 1'b0) begin errors++; $display("FAIL reset_front got %b want 0", front1); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read_line();
    bit ok;
    int base;
    logic [24:0] got, exp;
    base = done_cnt;
    cap1.delete();
    pulse_rd(10'd5);
    wait_done(base + 1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL read_timeout got no rd_line_done want pulse"); end
    checks++; if (cap1.size() != 5) begin errors++; $display("FAIL read_count got %0d want 5", cap1.size()); end
    for (int unsigned b = 0; b < 5; b++) begin
      exp = model_cmd(1'b0, 5, off1(model_front), b * 64);
      got = (b < cap1.size()) ? cap1[b] : 'x;
      checks++; if (got !== exp) begin errors++; $display("FAIL read_addr%0d got %h want %h", b, got, exp); end
    end
    checks++; if (done_cnt != base + 1) begin errors++; $display("FAIL read_done_pulses got %0d want 1", done_cnt - base); end
    checks++; if (front1 !== 1'b0) begin errors++; $display("FAIL read_front got %b want 0", front1); end
  endtask

  task automatic test_write();
    bit ok;
    int base;
    logic [24:0] got, exp;
    base = ack_cnt;
    cap1.delete();
    do_write(10'd5, 9'd16, ok);
    checks++; if (!ok) begin errors++; $display("FAIL write_timeout got no wr_ack want pulse"); end
    exp = model_cmd(1'b1, 5, off1(!model_front), 16);
    got = (cap1.size() > 0) ? cap1[0] : 'x;
    checks++; if (cap1.size() != 1 || got !== exp) begin errors++; $display("FAIL write_cmd got n=%0d %h want n=1 %h", cap1.size(), got, exp); end
    checks++; if (ack_cnt != base + 1) begin errors++; $display("FAIL write_ack_pulses got %0d want 1", ack_cnt - base); end
  endtask

  task automatic test_priority();
    bit ok;
    int dbase, abase;
    logic [24:0] got, exp;
    dbase = done_cnt;
    abase = ack_cnt;
    cap1.delete();
    wr_row = 10'd5; wr_col = 9'd16; wr_req = 1'b1;
    rd_line = 10'd5; rd_line_req = 1'b1;
    tick();
    rd_line_req = 1'b0;
    ok = 1'b0;
    for (int unsigned i = 0; i < 600; i++) begin
      @(negedge clk);
      if (ack1) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    wr_req = 1'b0;
    tick(); tick();
    checks++; if (!ok) begin errors++; $display("FAIL prio_timeout got no wr_ack want pulse"); end
    checks++; if (cap1.size() != 6) begin errors++; $display("FAIL prio_count got %0d want 6", cap1.size()); end
    for (int unsigned b = 0; b < 6; b++) begin
      exp = (b < 5) ? model_cmd(1'b0, 5, off1(model_front), b * 64)
                    : model_cmd(1'b1, 5, off1(!model_front), 16);
      got = (b < cap1.size()) ? cap1[b] : 'x;
      checks++; if (got !== exp) begin errors++; $display("FAIL prio_cmd%0d got %h want %h", b, got, exp); end
    end
    checks++;
    if (done_cnt != dbase + 1 || ack_cnt != abase + 1 || !(done_cyc < ack_cyc)) begin
      errors++;
      $display("FAIL prio_order got done=%0d@%0d ack=%0d@%0d want done before ack", done_cnt - dbase, done_cyc, ack_cnt - abase, ack_cyc);
    end
  endtask

  task automatic test_stall();
    bit ok, seen;
    int base;
    logic [23:0] held;
    logic [24:0] got, exp;
    base = done_cnt;
    cap1.delete();
    ready_level = 1'b0;
    tick();
    pulse_rd(10'd5);
    seen = 1'b0;
    for (int unsigned i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus1.mem_valid) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL stall_valid_timeout got 0 want 1"); end
    held = bus1.mem_addr;
    for (int unsigned i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (bus1.mem_valid !== 1'b1 || bus1.mem_addr !== held || cap1.size() != 0) begin
        errors++;
        $display("FAIL stall_hold%0d got v=%b a=%h n=%0d want v=1 a=%h n=0", i, bus1.mem_valid, bus1.mem_addr, cap1.size(), held);
      end
    end
    ready_level = 1'b1;
    wait_done(base + 1, ok);
    checks++; if (!ok || cap1.size() != 5) begin errors++; $display("FAIL stall_count got %0d want 5", cap1.size()); end
    for (int unsigned b = 0; b < 5; b++) begin
      exp = model_cmd(1'b0, 5, off1(model_front), b * 64);
      got = (b < cap1.size()) ? cap1[b] : 'x;
      checks++; if (got !== exp) begin errors++; $display("FAIL stall_addr%0d got %h want %h", b, got, exp); end
    end
  endtask

  task automatic test_swap();
    bit ok;
    int base;
    logic [24:0] got, exp;
    vsync_pulse = 1'b1; tick(); vsync_pulse = 1'b0; tick();
    checks++; if (front1 !== model_front) begin errors++; $display("FAIL vsync_only got %b want %b", front1, model_front); end
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    tick(); tick();
    vsync_pulse = 1'b1; tick(); vsync_pulse = 1'b0;
    model_front = !model_front;
    tick();
    checks++; if (front1 !== model_front || front2 !== model_front) begin errors++; $display("FAIL swap_front got %b/%b want %b", front1, front2, model_front); end
    base = done_cnt;
    cap1.delete();
    cap2.delete();
    pulse_rd(10'd5);
    wait_done(base + 1, ok);
    exp = model_cmd(1'b0, 5, off1(model_front), 0);
    got = (cap1.size() > 0) ? cap1[0] : 'x;
    checks++; if (!ok || got !== exp) begin errors++; $display("FAIL swap_read got %h want %h", got, exp); end
    exp = model_cmd(1'b0, 5, off2(model_front), 256);
    got = (cap2.size() > 4) ? cap2[4] : 'x;
    checks++; if (got !== exp) begin errors++; $display("FAIL swap_read_b1 got %h want %h", got, exp); end
  endtask

  task automatic test_wrap();
    bit ok;
    int base;
    logic [24:0] got, exp;
    base = done_cnt;
    cap1.delete();
    cap2.delete();
    pulse_rd(10'd500);
    wait_done(base + 1, ok);
    checks++; if (!ok || cap2.size() != 5) begin errors++; $display("FAIL wrap_count got %0d want 5", cap2.size()); end
    for (int unsigned b = 0; b < 5; b++) begin
      exp = model_cmd(1'b0, 500, off2(model_front), b * 64);
      got = (b < cap2.size()) ? cap2[b] : 'x;
      checks++; if (got !== exp) begin errors++; $display("FAIL wrap_addr%0d got %h want %h", b, got, exp); end
    end
    exp = model_cmd(1'b0, 500, off1(model_front), 0);
    got = (cap1.size() > 0) ? cap1[0] : 'x;
    checks++; if (got !== exp) begin errors++; $display("FAIL wrap_nowrap got %h want %h", got, exp); end
  endtask

  task automatic test_random();
    bit ok, both;
    int base;
    int unsigned op, line, row, col;
    logic [24:0] got, exp;
    rand_ready = 1'b1;
    for (int unsigned it = 0; it < 16; it++) begin
      op = $urandom_range(0, 3);
      cap1.delete();
      cap2.delete();
      case (op)
        0: begin
          line = $urandom_range(0, 1023);
          base = done_cnt;
          pulse_rd(line[9:0]);
          wait_done(base + 1, ok);
          checks++; if (!ok || cap1.size() != 5 || cap2.size() != 5) begin errors++; $display("FAIL rnd_read_count it%0d got %0d/%0d want 5", it, cap1.size(), cap2.size()); end
          for (int unsigned b = 0; b < 5; b++) begin
            exp = model_cmd(1'b0, line, off1(model_front), b * 64);
            got = (b < cap1.size()) ? cap1[b] : 'x;
            checks++; if (got !== exp) begin errors++; $display("FAIL rnd_read it%0d b%0d got %h want %h", it, b, got, exp); end
            exp = model_cmd(1'b0, line, off2(model_front), b * 64);
            got = (b < cap2.size()) ? cap2[b] : 'x;
            checks++; if (got !== exp) begin errors++; $display("FAIL rnd_read2 it%0d b%0d got %h want %h", it, b, got, exp); end
          end
        end
        1: begin
          row = $urandom_range(0, 1023);
          col = $urandom_range(0, 511);
          do_write(row[9:0], col[8:0], ok);
          exp = model_cmd(1'b1, row, off1(!model_front), col);
          got = (cap1.size() > 0) ? cap1[0] : 'x;
          checks++; if (!ok || cap1.size() != 1 || got !== exp) begin errors++; $display("FAIL rnd_write it%0d got %h want %h", it, got, exp); end
          exp = model_cmd(1'b1, row, off2(!model_front), col);
          got = (cap2.size() > 0) ? cap2[0] : 'x;
          checks++; if (got !== exp) begin errors++; $display("FAIL rnd_write2 it%0d got %h want %h", it, got, exp); end
        end
        2: begin
          both = $urandom_range(0, 1) != 0;
          swap_req = 1'b1;
          if (!both) begin tick(); swap_req = 1'b0; tick(); end
          vsync_pulse = 1'b1; tick();
          vsync_pulse = 1'b0; swap_req = 1'b0;
          model_front = !model_front;
          tick();
        end
        default: begin
          vsync_pulse = 1'b1; tick(); vsync_pulse = 1'b0; tick();
        end
      endcase
      checks++; if (front1 !== model_front || front2 !== model_front) begin errors++; $display("FAIL rnd_front it%0d op%0d got %b/%b want %b", it, op, front1, front2, model_front); end
    end
    rand_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    bit seen;
    int base;
    ready_level = 1'b0;
    tick();
    pulse_rd(10'd9);
    seen = 1'b0;
    for (int unsigned i = 0; i < 50; i++) begin
      tick();
      if (bus1.mem_valid) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL rstmid_valid_timeout got 0 want 1"); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus1.mem_valid !== 1'b0) begin errors++; $display("FAIL rstmid_drop got %b want 0", bus1.mem_valid); end
    tick(); tick();
    rst_n = 1'b1;
    model_front = 1'b0;
    ready_level = 1'b1;
    cap1.delete();
    base = done_cnt;
    repeat (20) tick();
    checks++; if (cap1.size() != 0 || done_cnt != base || bus1.mem_valid !== 1'b0) begin errors++; $display("FAIL rstmid_replay got n=%0d v=%b want n=0 v=0", cap1.size(), bus1.mem_valid); end
    checks++; if (front1 !== 1'b0) begin errors++; $display("FAIL rstmid_front got %b want 0", front1); end
  endtask

  initial begin
    rst_n = 1'b0;
    vsync_pulse = 1'b0;
    swap_req = 1'b0;
    rd_line_req = 1'b0;
    rd_line = '0;
    wr_req = 1'b0;
    wr_row = '0;
    wr_col = '0;
    ready_level = 1'b1;
    rand_ready = 1'b0;
    test_reset();
    test_read_line();
    test_write();
    test_priority();
    test_stall();
    test_swap();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_mem_scheduler.md
Name: vga_mem_scheduler

Overview:
Sequences and arbitrates SDRAM command issue for the VGA frame-buffer path. Serves two requesters: the display line fetcher (read, one scanline per request) and the pixel writer (write, one burst per request). Forms each command address as {2'b01, row + buffer_offset, column} and owns double-buffer selection, with the front/back swap taken at vsync. Sits between the VGA timing/line-buffer logic and the SDRAM controller command port.

Parameters:
ROW_WIDTH, 13, SDRAM row address bits
COL_WIDTH, 9, SDRAM column address bits
BANK_WIDTH, 2, bank bits; bank value is fixed at 2'b01
BURST_LEN, 64, column step between successive read bursts of one line
BURSTS_PER_LINE, 5, read commands issued per line request
BUF0_OFFSET, 0, row offset of buffer 0 (ROW_WIDTH bits)
BUF1_OFFSET, 512, row offset of buffer 1 (ROW_WIDTH bits)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
vsync_pulse  in  1  one-cycle start-of-frame strobe
swap_req  in  1  pulse: writer has finished the back buffer
rd_line_req  in  1  pulse: fetch display line rd_line
rd_line  in  10  display row to fetch
rd_line_done  out  1  one-cycle pulse when the last burst of a line is accepted
wr_req  in  1  level: write burst pending, held until wr_ack
wr_row  in  10  write row
wr_col  in  COL_WIDTH  write start column
wr_ack  out  1  one-cycle pulse when the write command is accepted
mem_valid  out  1  command valid to SDRAM controller
mem_write  out  1  1 = write, 0 = read
mem_addr  out  24  {bank, row, col}
mem_ready  in  1  SDRAM controller accepts the command when high with mem_valid
front_buf  out  1  buffer currently displayed (0/1)

Behaviour:
- Reset: all outputs 0, FSM IDLE, front_buf=0, swap_pending=0, rd_pending=0, burst counter 0.
- Handshake: a command is transferred when mem_valid && mem_ready on a rising edge. mem_valid, mem_write and mem_addr stay stable until transfer. mem_valid never drops without a transfer, except on reset.
- rd_line_req sets rd_pending and latches rd_line. A request arriving while rd_pending=1 overwrites the latched line and is still served once; this is an overrun and is not flagged.
- FSM states: IDLE, RD_CMD, WR_CMD.
  - IDLE: if rd_pending -> RD_CMD, burst counter=0, latch rd_off = offset(front_buf). Else if wr_req -> WR_CMD, latch wr_off = offset(~front_buf). Reads have strict priority.
  - RD_CMD: mem_write=0; col = burst_cnt*BURST_LEN (truncated to COL_WIDTH). On transfer, burst_cnt++. On transfer with burst_cnt==BURSTS_PER_LINE-1: pulse rd_line_done, clear rd_pending, -> IDLE.
  - WR_CMD: mem_write=1; col=wr_col, row=wr_row. On transfer: pulse wr_ack, -> IDLE. Not preemptible by a read.
- mem_valid is registered and asserts the cycle after the state is entered. Minimum one IDLE cycle between commands.
- Address: row field = (row_in zero-extended + latched offset) mod 2^ROW_WIDTH, wrapping silently. mem_addr = {2'b01, row field, col}.
- Swap: swap_req sets swap_pending. On vsync_pulse with swap_pending (including swap_req in the same cycle): toggle front_buf, clear swap_pending. vsync_pulse without a pending swap leaves front_buf unchanged. A toggle mid-command does not affect that command, because offsets are latched.
- Reset asserted mid-command drops mem_valid immediately. Lost requests are not replayed.

Decomposition:
- Shared package vga_mem_pkg: ROW_WIDTH, COL_WIDTH, BANK_WIDTH, the VGA_BANK=2'b01 constant, and the FSM state enum.
- Sub-module vga_addr_form (combinational row+offset, column concatenation), instantiated once on the muxed row, offset and column.

Test Plan:
- Reset, then rd_line_req with rd_line=5 and mem_ready=1 -> five reads at 0x400A00, 0x400A40, 0x400A80, 0x400AC0, 0x400B00; one rd_line_done pulse; front_buf=0.
- wr_req with wr_row=5, wr_col=16 while front_buf=0 -> single write at 0x440A10 (row 517), one wr_ack pulse.
- wr_req and rd_line_req in the same IDLE cycle -> all five reads issue first, then the write. wr_req is held throughout and no wr_ack appears before rd_line_done.
- mem_ready held low 10 cycles during a read -> mem_valid and mem_addr stable all 10 cycles, no counter advance.
- swap_req then vsync_pulse -> front_buf=1, and the next line-5 read is at 0x440A00. A vsync_pulse with no prior swap_req leaves front_buf unchanged.
- BUF1_OFFSET=8000, front_buf=1, rd_line=500 -> row wraps to 308, first address 0x426800.
